// File: rtl/sw_debounce_if.sv
// Switch conditioning bus: raw pins in, debounced word and edge pulses out.
// Signal names mirror the block's external pin names so board-level wiring reads one-to-one.
interface sw_debounce_if #(
    parameter int NUM_SW = 17
);
    logic [NUM_SW-1:0] sw_raw_i;
    logic [31:0]       io_sw_o;
    logic [NUM_SW-1:0] sw_rise_o;
    logic [NUM_SW-1:0] sw_fall_o;
    logic              sw_chg_o;

    modport master (
        output sw_raw_i,
        input  io_sw_o,
        input  sw_rise_o,
        input  sw_fall_o,
        input  sw_chg_o
    );

    modport slave (
        input  sw_raw_i,
        output io_sw_o,
        output sw_rise_o,
        output sw_fall_o,
        output sw_chg_o
    );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit switch debouncer: 2-flop sync, shared sample-tick prescaler, per-bit stability counter.
// Latency 2 + (STABLE_TICKS-1..STABLE_TICKS)*TICK_DIV + 1 cycles; no backpressure, outputs are pure registers.
module sw_debounce #(
    parameter int NUM_SW       = 17,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    sw_debounce_if.slave sw
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] C_MAX  = CW'(STABLE_TICKS - 1);

    logic [NUM_SW-1:0] meta_q;
    logic [NUM_SW-1:0] sync_q;
    logic [NUM_SW-1:0] deb_q;
    logic [NUM_SW-1:0] deb_d;
    logic [NUM_SW-1:0] rise_q;
    logic [NUM_SW-1:0] rise_d;
    logic [NUM_SW-1:0] fall_q;
    logic [NUM_SW-1:0] fall_d;
    logic [CW-1:0]     cnt_q [NUM_SW];
    logic [CW-1:0]     cnt_d [NUM_SW];
    logic [PW-1:0]     ps_q;
    logic [PW-1:0]     ps_d;
    logic              tick;
    logic              chg_q;

    always_comb begin
        tick = (ps_q == PS_MAX);
        ps_d = tick ? '0 : ps_q + PW'(1);
    end

    // A sample that agrees with the debounced value wipes any accumulated count,
    // so a bounce anywhere inside the window forces a full restart.
    always_comb begin
        deb_d  = deb_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sync_q[i] == deb_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == C_MAX) begin
                    deb_d[i]  = sync_q[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = sync_q[i];
                    fall_d[i] = ~sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
            deb_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            chg_q  <= 1'b0;
            ps_q   <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            meta_q <= sw.sw_raw_i;
            sync_q <= meta_q;
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            chg_q  <= |(rise_d | fall_d);
            ps_q   <= ps_d;
            for (int i = 0; i < NUM_SW; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw.io_sw_o   = 32'(deb_q);
    assign sw.sw_rise_o = rise_q;
    assign sw.sw_fall_o = fall_q;
    assign sw.sw_chg_o  = chg_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce (NUM_SW=17, TICK_DIV=4, STABLE_TICKS=3) with a queued scoreboard.
module tb_sw_debounce;
    localparam int N = 17;

    typedef struct {
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [31:0]  io;
        int           issue;
        int           lo;
        int           hi;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic upper_bad = 1'b0;
    exp_t q[$];

    sw_debounce_if #(.NUM_SW(N)) bus ();

    sw_debounce #(.NUM_SW(N), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sw    (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [N-1:0] r, input logic [N-1:0] f, input logic [31:0] io);
        exp_t e;
        e.rise = r; e.fall = f; e.io = io; e.issue = cyc; e.lo = 11; e.hi = 15;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        int w = 0;
        while (q.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk({"drain_", name}, q.size(), 0);
        q.delete();
    endtask

    task automatic monitor();
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (bus.io_sw_o[31:N] != '0) upper_bad = 1'b1;
            if (!rst && (bus.sw_chg_o || (|bus.sw_rise_o) || (|bus.sw_fall_o))) begin
                chk("chg_or", {31'd0, bus.sw_chg_o}, {31'd0, |(bus.sw_rise_o | bus.sw_fall_o)});
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: rise %h fall %h io %h, none expected (cycle %0d)",
                             bus.sw_rise_o, bus.sw_fall_o, bus.io_sw_o, cyc);
                end else begin
                    e = q.pop_front();
                    chk("rise", 32'(bus.sw_rise_o), 32'(e.rise));
                    chk("fall", 32'(bus.sw_fall_o), 32'(e.fall));
                    chk("io_sw", bus.io_sw_o, e.io);
                    lat = cyc - e.issue;
                    n_cmp++;
                    if (lat < e.lo || lat > e.hi) begin
                        n_fail++;
                        $display("FAIL latency: got %0d cycles, required %0d..%0d", lat, e.lo, e.hi);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.sw_raw_i = '0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_io", bus.io_sw_o, 32'h0);
        chk("rst_rise", 32'(bus.sw_rise_o), 32'h0);
        chk("rst_fall", 32'(bus.sw_fall_o), 32'h0);
        chk("rst_chg", {31'd0, bus.sw_chg_o}, 32'h0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("idle_io", bus.io_sw_o, 32'h0);

        // Single clean rise then fall on bit 5
        bus.sw_raw_i[5] = 1'b1;
        push(17'h20, 17'h0, 32'h20);
        drain("rise5");
        repeat (10) @(negedge clk);
        bus.sw_raw_i[5] = 1'b0;
        push(17'h0, 17'h20, 32'h0);
        drain("fall5");

        // Bit 0 bouncing every 5 cycles never holds for 3 ticks
        repeat (5) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            bus.sw_raw_i[0] = ~bus.sw_raw_i[0];
            repeat (5) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        chk("bounce_io", bus.io_sw_o, 32'h0);

        // Simultaneous acceptance on bits 3 and 16
        bus.sw_raw_i[3]  = 1'b1;
        bus.sw_raw_i[16] = 1'b1;
        push(17'h10008, 17'h0, 32'h10008);
        drain("rise3_16");
        repeat (10) @(negedge clk);
        bus.sw_raw_i = '0;
        push(17'h0, 17'h10008, 32'h0);
        drain("fall3_16");

        // Reset after two ticks of a pending rise on bit 2
        repeat (7) @(negedge clk);
        bus.sw_raw_i[2] = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_io", bus.io_sw_o, 32'h0);
        rst = 1'b0;
        push(17'h4, 17'h0, 32'h4);
        drain("rise2_after_rst");

        // All bits high, then all fall together
        repeat (10) @(negedge clk);
        bus.sw_raw_i = '1;
        push(17'h1FFFB, 17'h0, 32'h1FFFF);
        drain("rise_all");
        repeat (10) @(negedge clk);
        bus.sw_raw_i = '0;
        push(17'h0, 17'h1FFFF, 32'h0);
        drain("fall_all");

        repeat (20) @(negedge clk);
        chk("upper_zero", {31'd0, upper_bad}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter NUM_SW, default 17, number of conditioned switch inputs (legal 1..32).
REQ-002 SHALL have parameter TICK_DIV, default 50000, clock cycles per sample tick (legal >= 1; 1 = tick every cycle).
REQ-003 SHALL have parameter STABLE_TICKS, default 4, consecutive differing samples required to accept a change (legal >= 1).
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port sw_raw_i  input  NUM_SW  raw board switch pins, asynchronous to clk_i.
REQ-007 SHALL have port io_sw_o  output  32  debounced switch word to the CPU switch input; bits [NUM_SW-1:0] debounced, bits [31:NUM_SW] constant 0.
REQ-008 SHALL have port sw_rise_o  output  NUM_SW  one-cycle pulse per bit on an accepted 0->1 change.
REQ-009 SHALL have port sw_fall_o  output  NUM_SW  one-cycle pulse per bit on an accepted 1->0 change.
REQ-010 SHALL have port sw_chg_o  output  1  OR-reduction of sw_rise_o | sw_fall_o, same cycle.

Function
REQ-011 Each bit SHALL pass through a two-flop synchronizer; only the second flop (sync) feeds downstream logic.
REQ-012 A prescaler SHALL count 0..TICK_DIV-1, assert internal tick for exactly the cycle when count == TICK_DIV-1, then wrap to 0; it free-runs and is never stalled.
REQ-013 Each bit SHALL hold a debounced state d and a stability counter c sized for 0..STABLE_TICKS-1.
REQ-014 On non-tick cycles d and c SHALL hold.
REQ-015 On a tick with sync == d, c SHALL clear to 0.
REQ-016 On a tick with sync != d and c < STABLE_TICKS-1, c SHALL increment by 1.
REQ-017 On a tick with sync != d and c == STABLE_TICKS-1, d SHALL take sync and c SHALL clear to 0 (accepted change).
REQ-018 Any tick with sync == d before acceptance SHALL restart the count; no partial credit survives a bounce.
REQ-019 sw_rise_o[i]/sw_fall_o[i] SHALL be registered and assert in the same cycle io_sw_o[i] first shows the new value, for exactly one cycle.
REQ-020 Bits SHALL be fully independent; simultaneous acceptances on several bits SHALL produce their pulses in the same cycle.
REQ-021 Latency from a clean raw transition to io_sw_o update SHALL be at least 2 + (STABLE_TICKS-1)*TICK_DIV + 1 and at most 2 + STABLE_TICKS*TICK_DIV + 1 cycles, depending on prescaler phase.
REQ-022 With STABLE_TICKS == 1 a change SHALL be accepted on the first tick that samples it.
REQ-023 Outputs SHALL be driven only from registers (no combinational path from sw_raw_i).

Reset
REQ-024 While rst_i is high at a clock edge: synchronizer flops, prescaler, every d, every c, sw_rise_o, sw_fall_o SHALL clear to 0; io_sw_o = 32'h0, sw_chg_o = 0.
REQ-025 Reset asserted mid-count SHALL discard partial counts; after release, counting restarts from prescaler 0.
REQ-026 A switch held at 1 through reset release SHALL be treated as a new 0->1 change: normal debounce, then one sw_rise_o pulse.

Verification (bench parameters NUM_SW=17, TICK_DIV=4, STABLE_TICKS=3)
REQ-027 Reset, raw = 0 -> io_sw_o = 32'h0, all pulses 0 for 50 cycles.
REQ-028 Raw bit 5 0->1 held clean -> io_sw_o = 32'h20 within 11..15 cycles; sw_rise_o = 17'h20 and sw_chg_o = 1 for that single cycle; sw_fall_o stays 0.
REQ-029 Raw bit 0 toggles 1/0 every 5 cycles for 60 cycles, then settles at 0 -> io_sw_o[0] never changes, no pulses.
REQ-030 Raw bits 3 and 16 rise in the same cycle -> both accepted in the same cycle; io_sw_o = 32'h10008, sw_rise_o = 17'h10008 for one cycle.
REQ-031 Raw bit 2 rises, rst_i pulsed 1 cycle after 2 ticks -> io_sw_o stays 0 through reset; bit accepted 11..15 cycles after rst_i deasserts, with one rise pulse.
REQ-032 Raw = 17'h1FFFF settled, then all bits fall -> io_sw_o goes 32'h1FFFF -> 32'h0 in one cycle; sw_fall_o = 17'h1FFFF for one cycle; io_sw_o[31:17] = 0 throughout.
